// File: rtl/pipe_trace_emitter.sv
// Per-cycle MIPS pipeline trace emitter: classifies samples, buffers them in a FIFO, halts at a cycle limit.
// Optional build macro TRACE_SKIP_NOP_EN: NOP samples are never recorded and never count as drops.
module pipe_trace_emitter #(
  parameter int DEPTH       = 16,
  parameter int CYCLE_LIMIT = 200
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cap_en,
  input  logic [31:0]              pc,
  input  logic [5:0]               opcode,
  input  logic [5:0]               funct,
  input  logic [4:0]               rs,
  input  logic [4:0]               rt,
  input  logic [4:0]               rd,
  input  logic [31:0]              wd,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [3:0]               out_cls,
  output logic [31:0]              out_wd,
  output logic [15:0]              out_cycle,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     halt
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = 32 + 4 + 32 + 16;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
  localparam logic [15:0] LIMIT    = 16'(CYCLE_LIMIT);

  logic [RW-1:0] mem [DEPTH];
  logic [AW:0]   wptr, rptr;
  logic [15:0]   cycle;
  logic [15:0]   cycle_nxt;
  logic [3:0]    cls;
  logic [31:0]   wd_masked;
  logic          full, empty, keep, push, pop, drop;
  logic [RW-1:0] head;

  always_comb begin
    cls = 4'd15;
    case (opcode)
      6'd0: begin
        case (funct)
          6'd32:   cls = 4'd1;
          6'd34:   cls = 4'd2;
          6'd36:   cls = 4'd3;
          6'd37:   cls = 4'd4;
          6'd25:   cls = 4'd6;
          6'd16:   cls = 4'd7;
          6'd18:   cls = 4'd8;
          6'd0:    cls = (rs == 5'd0 && rt == 5'd0 && rd == 5'd0) ? 4'd0 : 4'd5;
          default: cls = 4'd15;
        endcase
      end
      6'd35:   cls = 4'd9;
      6'd43:   cls = 4'd10;
      6'd4:    cls = 4'd11;
      6'd2:    cls = 4'd12;
      6'd8:    cls = 4'd13;
      6'd12:   cls = 4'd14;
      default: cls = 4'd15;
    endcase
  end

`ifdef TRACE_SKIP_NOP_EN
  assign keep = (cls != 4'd0);
`else
  assign keep = 1'b1;
`endif

  assign wd_masked = (opcode == 6'd0) ? wd : 32'd0;
  assign count     = wptr - rptr;
  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign cycle_nxt = cycle + 16'd1;

  // Handshake: a record transfers on any rising edge where out_valid && out_ready;
  // out_valid never depends on out_ready, and the head holds until it transfers.
  assign pop  = out_valid && out_ready;
  assign push = cap_en && !halt && keep && (!full || pop);
  assign drop = cap_en && !halt && keep && full && !pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr     <= '0;
      rptr     <= '0;
      cycle    <= '0;
      overflow <= 1'b0;
      halt     <= 1'b0;
    end else begin
      if (!halt) begin
        cycle <= cycle_nxt;
        if (cycle_nxt == LIMIT) halt <= 1'b1;
      end
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
      if (drop) overflow <= 1'b1;
    end
  end

  // Storage carries no reset; empty-forcing below hides stale entries.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= {pc, cls, wd_masked, cycle};
  end

  assign out_valid = !empty;
  assign head      = empty ? '0 : mem[rptr[AW-1:0]];
  assign out_pc    = head[RW-1 -: 32];
  assign out_cls   = head[RW-33 -: 4];
  assign out_wd    = head[RW-37 -: 32];
  assign out_cycle = head[15:0];
endmodule

// File: tb/tb_pipe_trace_emitter.sv
// Directed bench for pipe_trace_emitter: classification table, overflow, wrap ordering, halt and async reset.
module tb_pipe_trace_emitter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cap_en = 1'b0;
  logic [31:0] pc = '0;
  logic [5:0]  opcode = '0;
  logic [5:0]  funct = '0;
  logic [4:0]  rs = '0, rt = '0, rd = '0;
  logic [31:0] wd = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [3:0]  out_cls;
  logic [31:0] out_wd;
  logic [15:0] out_cycle;
  logic [4:0]  count;
  logic        overflow;
  logic        halt;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  pipe_trace_emitter #(.DEPTH(16), .CYCLE_LIMIT(200)) dut (
    .clk(clk), .rst(rst), .cap_en(cap_en), .pc(pc), .opcode(opcode), .funct(funct),
    .rs(rs), .rt(rt), .rd(rd), .wd(wd), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_cls(out_cls), .out_wd(out_wd), .out_cycle(out_cycle),
    .count(count), .overflow(overflow), .halt(halt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_instr(input logic [31:0] p, input logic [5:0] op, input logic [5:0] fn,
                           input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                           input logic [31:0] w);
    pc = p; opcode = op; funct = fn; rs = s; rt = t; rd = d; wd = w;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; cap_en = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_halt", 32'(halt), 32'd0);
    check("rst_pc", out_pc, 32'd0);
    check("rst_cls", 32'(out_cls), 32'd0);
    check("rst_wd", out_wd, 32'd0);
    check("rst_cycle", 32'(out_cycle), 32'd0);
    rst = 1'b1;
  endtask

  logic [5:0] t_op  [17] = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd35,
                             6'd43, 6'd4, 6'd2, 6'd8, 6'd12, 6'd0, 6'd15, 6'd0};
  logic [5:0] t_fn  [17] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd0, 6'd25, 6'd16, 6'd18, 6'd32,
                             6'd32, 6'd32, 6'd32, 6'd32, 6'd32, 6'd42, 6'd32, 6'd0};
  logic [3:0] t_cls [17] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9,
                             4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd15, 4'd0};

  initial begin
    // Single ADD capture right after reset.
    do_reset();
    set_instr(32'h4, 6'd0, 6'd32, 5'd1, 5'd2, 5'd3, 32'd7);
    cap_en = 1'b1;
    @(negedge clk);
    cap_en = 1'b0;
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_cls", 32'(out_cls), 32'd1);
    check("t1_pc", out_pc, 32'h4);
    check("t1_wd", out_wd, 32'd7);
    check("t1_cycle", 32'(out_cycle), 32'd0);
    check("t1_count", 32'(count), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    check("t1_drained", 32'(count), 32'd0);

    // Classification table, streamed with the consumer always ready.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      logic [4:0] s, t, d;
      logic [31:0] w;
      s = (i == 4 || i == 16) ? 5'd0 : 5'd1;
      t = (i == 16) ? 5'd0 : 5'd2;
      d = (i == 16) ? 5'd0 : 5'd3;
      w = 32'h100 + 32'(i);
      set_instr(32'h400 + 32'(4 * i), t_op[i], t_fn[i], s, t, d, w);
      cap_en = 1'b1;
      @(negedge clk);
`ifdef TRACE_SKIP_NOP_EN
      if (t_cls[i] == 4'd0) begin
        check("cls_nop_valid", 32'(out_valid), 32'd0);
        check("cls_nop_count", 32'(count), 32'd0);
        check("cls_nop_pc", out_pc, 32'd0);
        continue;
      end
`endif
      check("cls_valid", 32'(out_valid), 32'd1);
      check("cls_count", 32'(count), 32'd1);
      check("cls_code", 32'(out_cls), 32'(t_cls[i]));
      check("cls_pc", out_pc, 32'h400 + 32'(4 * i));
      check("cls_wd", out_wd, (t_op[i] == 6'd0) ? w : 32'd0);
      check("cls_cycle", 32'(out_cycle), 32'(i));
    end
    cap_en = 1'b0;
    @(negedge clk);
    check("cls_drained", 32'(count), 32'd0);

    // Fill to full with one drop, then a simultaneous pop and push.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      set_instr(32'h1000 + 32'(4 * i), 6'd35, 6'd0, 5'd1, 5'd2, 5'd3, 32'(i));
      cap_en = 1'b1;
      @(negedge clk);
      if (i < 16) check("ovf_early", 32'(overflow), 32'd0);
    end
    check("ovf_count", 32'(count), 32'd16);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_head_pc", out_pc, 32'h1000);
    check("ovf_head_cycle", 32'(out_cycle), 32'd0);
    set_instr(32'h2000, 6'd35, 6'd0, 5'd1, 5'd2, 5'd3, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    cap_en = 1'b0;
    check("pp_count", 32'(count), 32'd16);
    check("pp_flag", 32'(overflow), 32'd1);
    check("pp_head_cycle", 32'(out_cycle), 32'd1);
    for (int i = 1; i < 16; i++) exp_q.push_back(32'h1000 + 32'(4 * i));
    exp_q.push_back(32'h2000);
    for (int i = 0; i < 16; i++) begin
      check("drain_valid", 32'(out_valid), 32'd1);
      check("drain_pc", out_pc, exp_q.pop_front());
      @(negedge clk);
    end
    check("drain_empty", 32'(count), 32'd0);

    // Continuous capture with ready consumer across several pointer wraps.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      set_instr(32'h3000 + 32'(4 * i), 6'd0, 6'd34, 5'd1, 5'd2, 5'd3, 32'(i));
      cap_en = 1'b1;
      @(negedge clk);
      check("wrap_count", 32'(count), 32'd1);
      check("wrap_cycle", 32'(out_cycle), 32'(i));
      check("wrap_pc", out_pc, 32'h3000 + 32'(4 * i));
    end
    cap_en = 1'b0;
    @(negedge clk);

    // Capture every cycle up to the halt; leave the last five records queued.
    do_reset();
    for (int i = 0; i < 200; i++) begin
      set_instr(32'h8000 + 32'(4 * i), 6'd0, 6'd32, 5'd1, 5'd2, 5'd3, 32'(i));
      cap_en = 1'b1;
      out_ready = (i < 196);
      @(negedge clk);
      check("halt_flag", 32'(halt), (i == 199) ? 32'd1 : 32'd0);
      check("halt_head", 32'(out_cycle), (i < 196) ? 32'(i) : 32'd195);
    end
    check("halt_count", 32'(count), 32'd5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_halt_count", 32'(count), 32'd5);
      check("post_halt_ovf", 32'(overflow), 32'd0);
      check("post_halt_halt", 32'(halt), 32'd1);
    end
    cap_en = 1'b0;

    // Asynchronous reset between clock edges.
    #2 rst = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_count", 32'(count), 32'd0);
    check("arst_halt", 32'(halt), 32'd0);
    check("arst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("after_arst_halt", 32'(halt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_trace_emitter.md
# pipe_trace_emitter

Per-cycle instruction trace emitter for the MIPS pipeline CPU. Samples the pipeline's current PC, opcode/funct, register fields and register-file write data, classifies each sample into a 4-bit mnemonic code, and buffers the records in a FIFO. A downstream consumer drains the FIFO over a valid/ready handshake. A built-in cycle counter asserts a sticky halt at a fixed cycle limit, which ends the run.

## Interface
Parameters:
- DEPTH, 16: FIFO entries; power of two, ≥2.
- CYCLE_LIMIT, 200: cycle count at which halt asserts; 1..65535.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- cap_en  in  1  sample the current pipeline fields this cycle.
- pc  in  32  current PC.
- opcode  in  6  instruction [31:26].
- funct  in  6  instruction [5:0].
- rs, rt, rd  in  5 each  register fields.
- wd  in  32  register-file write data.
- out_valid  out  1  head record present.
- out_ready  in  1  consumer accepts head record.
- out_pc  out  32  head record PC.
- out_cls  out  4  head record class code.
- out_wd  out  32  head record write data (0 unless R-type).
- out_cycle  out  16  cycle counter value at capture.
- count  out  $clog2(DEPTH)+1  occupancy.
- overflow  out  1  sticky: a capture was dropped.
- halt  out  1  sticky: cycle limit reached.

## Operation
- Classification (combinational on inputs):
  - opcode 0: funct 32→1 ADD, 34→2 SUB, 36→3 AND, 37→4 OR, 25→6 MULTU, 16→7 MFHI, 18→8 MFLO.
  - opcode 0, funct 0: rs=rt=rd=0→0 NOP, otherwise 5 SLL.
  - opcode 0, any other funct→15.
  - opcode 35→9 LW, 43→10 SW, 4→11 BEQ, 2→12 J, 8→13 ADDI, 12→14 ANDI, any other→15 UNKNOWN.
- Record fields: {pc, cls, wd_masked, cycle}. wd_masked = wd when opcode==0, else 0.
- Push: cap_en && !halt && (!full || pop).
- Drop: cap_en && !halt && full && !pop → record discarded, overflow←1.
- Pop: out_valid && out_ready.
- Pointers are mod-DEPTH with an extra wrap bit. full = count==DEPTH; empty = count==0.
- Cycle counter (16-bit): 0 at reset, +1 each clock while !halt. When the incremented value equals CYCLE_LIMIT, halt←1 and the counter freezes at CYCLE_LIMIT.
- After halt: captures are ignored (not counted as drops). Draining continues normally.
- Reset (rst=0, any time, including mid-drain): pointers, count, counter, overflow and halt clear to 0. out_valid=0 immediately (asynchronous). FIFO storage contents are don't-care.

## Timing
- Reset values: out_valid=0, count=0, overflow=0, halt=0, out_cycle=0, out_pc=0, out_cls=0, out_wd=0 (out_* forced 0 while empty).
- Capture latency: a record captured at edge N is on out_* with out_valid=1 from edge N (after the update) until it is popped. The first-in head is visible one cycle after cap_en was sampled.
- out_* hold stable while out_valid && !out_ready.
- Simultaneous push and pop:
  - When full: both happen, count unchanged, no overflow.
  - When empty: no pop occurs (out_valid=0); the push lands and count becomes 1.
- out_cycle holds the counter value before the capture edge's increment.
- halt rises at the edge where the counter reaches CYCLE_LIMIT. A cap_en on that same edge is still accepted.

## Configuration
- TRACE_SKIP_NOP_EN defined: samples classified 0 (NOP) are never pushed and never set overflow. All other behaviour is unchanged.
- TRACE_SKIP_NOP_EN undefined: NOP samples are recorded like any other.

## Test plan
- Reset, then cap_en=1 for one cycle with opcode=0, funct=32, pc=0x4, wd=7 → next cycle out_valid=1, out_cls=1, out_pc=0x4, out_wd=7, out_cycle=0, count=1.
- opcode=35, wd=0x55 captured → out_cls=9, out_wd=0. All-zero instruction → out_cls=0, or no record when TRACE_SKIP_NOP_EN is defined.
- out_ready=0, 17 consecutive captures with DEPTH=16 → count=16, overflow=1, head is the first record. Then a pop plus push in the same cycle → count stays 16 and overflow stays 1.
- out_ready=1 with continuous captures → count ≤1 every cycle. Records arrive in order with out_cycle incrementing by 1 across pointer wrap (more than 32 records).
- Capture every cycle → halt=1 at the edge where the counter reaches 200. Cycles 0..199 are recorded; later cap_en is ignored and the counter stays at 200.
- rst pulsed low with count=5 and halt=1 → out_valid, count, halt and overflow are 0 before the next clock edge.
